// File: rtl/ireg_skew_pipe_pkg.sv
// ireg_pkg: shared types for the systolic-array edge input buffer.
//   lane_data_t  - one signed lane word at the default width
//   ireg_mode_e  - tap mode: uniform delay or triangular skew
package ireg_pkg;

  localparam int IREG_WIDTH = 8;

  typedef logic signed [IREG_WIDTH-1:0] lane_data_t;

  typedef enum logic {
    IREG_UNIFORM = 1'b0,
    IREG_SKEW    = 1'b1
  } ireg_mode_e;

endpackage

// File: rtl/ireg_skew_pipe_lane.sv
// ireg_lane: one lane of the edge buffer, a DEPTH-stage data+valid shift chain.
// Optional build macro: IREG_SKEW_PIPE_ZERO_GATE_EN (stage 0 loads zero data
// for invalid input slots).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en_i          shift all stages by one
//   clr_i         synchronous clear of all data and valids (wins over en_i)
//   valid_i       lane input valid
//   data_i        lane input word
//   stage_data_o  all stage words, stage s at [s*WIDTH +: WIDTH]
//   stage_vld_o   all stage valids, stage s at bit s
module ireg_lane
  import ireg_pkg::*;
#(
  parameter int WIDTH = IREG_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic                    valid_i,
  input  logic signed [WIDTH-1:0] data_i,
  output logic [DEPTH*WIDTH-1:0]  stage_data_o,
  output logic [DEPTH-1:0]        stage_vld_o
);

  logic signed [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]        vld_q;
  logic signed [WIDTH-1:0] load_d;

`ifdef IREG_SKEW_PIPE_ZERO_GATE_EN
  // Invalid slots enter the array as zero padding.
  assign load_d = valid_i ? data_i : '0;
`else
  assign load_d = data_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
      vld_q <= '0;
    end else if (clr_i) begin
      for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
      vld_q <= '0;
    end else if (en_i) begin
      data_q[0] <= load_d;
      for (int s = 1; s < DEPTH; s++) data_q[s] <= data_q[s-1];
      vld_q <= {vld_q[DEPTH-2:0], valid_i};
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    assign stage_data_o[gi*WIDTH +: WIDTH] = data_q[gi];
  end
  assign stage_vld_o = vld_q;

endmodule

// File: rtl/ireg_skew_pipe.sv
// ireg_skew_pipe: multi-lane horizontal input buffer feeding the PE grid.
// Uniform mode delays every lane DEPTH enabled cycles; skew mode delays lane k
// by k+1 cycles to build diagonal wavefronts. Mode changes only when drained.
// Optional build macro: IREG_SKEW_PIPE_ZERO_GATE_EN (zero padding of invalid
// slots, implemented in ireg_lane).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          advance all stages
//   clr         synchronous clear of all stages (mode kept)
//   skew_req    requested mode, 1 = skew
//   i_valid     per-lane input valid
//   i_data      lane words, lane k at [k*WIDTH +: WIDTH]
//   o_valid     per-lane output valid
//   o_data      lane outputs, same packing
//   o_mode      active mode
//   o_busy      any stage holds a valid word
module ireg_skew_pipe
  import ireg_pkg::*;
#(
  parameter int WIDTH = IREG_WIDTH,
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   skew_req,
  input  logic [LANES-1:0]       i_valid,
  input  logic [LANES*WIDTH-1:0] i_data,
  output logic [LANES-1:0]       o_valid,
  output logic [LANES*WIDTH-1:0] o_data,
  output logic                   o_mode,
  output logic                   o_busy
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < LANES) begin : g_depth_check
    $error("ireg_skew_pipe: DEPTH must be >= LANES");
  end

  ireg_mode_e             mode_q, mode_d;
  logic [DEPTH*WIDTH-1:0] stg_data [LANES];
  logic [DEPTH-1:0]       stg_vld  [LANES];
  logic [LANES-1:0]       lane_busy;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [IDXW-1:0] tap_idx;

    ireg_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (en),
      .clr_i        (clr),
      .valid_i      (i_valid[gi]),
      .data_i       (i_data[gi*WIDTH +: WIDTH]),
      .stage_data_o (stg_data[gi]),
      .stage_vld_o  (stg_vld[gi])
    );

    // Skew taps stage k (k+1 cycle latency); uniform taps the last stage.
    assign tap_idx = (mode_q == IREG_SKEW) ? IDXW'(gi) : IDXW'(DEPTH - 1);
    assign o_valid[gi]                 = stg_vld[gi][tap_idx];
    assign o_data[gi*WIDTH +: WIDTH]   = stg_data[gi][tap_idx*WIDTH +: WIDTH];
    // Stages past the skew tap are unobserved but still count as in flight.
    assign lane_busy[gi]               = |stg_vld[gi];
  end

  assign o_busy = |lane_busy;
  assign o_mode = (mode_q == IREG_SKEW);

  // A new mode is taken only when nothing is in flight and nothing is being
  // admitted on this edge, so no word ever sees two different tap points.
  always_comb begin
    mode_d = mode_q;
    if (!clr && !o_busy && (!en || (i_valid == '0)))
      mode_d = skew_req ? IREG_SKEW : IREG_UNIFORM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= IREG_UNIFORM;
    else        mode_q <= mode_d;
  end

endmodule

// File: doc/ireg_skew_pipe.md
Name: ireg_skew_pipe

Overview:
- Multi-lane, multi-stage horizontal input buffer for the systolic array edge.
- Carries LANES signed data words plus per-lane valid through a DEPTH-stage register chain, with shared enable and synchronous clear.
- Runtime mode selects either a uniform delay, or a triangular skew where lane k is delayed k+1 cycles, to feed diagonal wavefronts into the PE grid.
- Mode changes are accepted only when the pipe is drained.

Parameters:
- WIDTH, 8, bits per lane data word (signed).
- LANES, 4, number of parallel lanes.
- DEPTH, 4, register stages per lane; must be >= LANES (checked by elaboration-time assertion).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  advance all stages by one.
- clr  in  1  synchronous clear of all stages and valids.
- skew_req  in  1  requested mode: 1 = skew, 0 = uniform.
- i_valid  in  LANES  per-lane input valid.
- i_data  in  LANES*WIDTH  signed lane words, lane k at bits [k*WIDTH +: WIDTH].
- o_valid  out  LANES  per-lane output valid.
- o_data  out  LANES*WIDTH  signed lane outputs, same packing as i_data.
- o_mode  out  1  active mode register.
- o_busy  out  1  any stage valid bit set.

Behaviour:
- Storage: per lane k, stages s = 0..DEPTH-1, each holding data[WIDTH] and vld[1].
- Reset (rst_n = 0, async): all stage data = 0, vld = 0, mode = 0. Outputs: o_valid = 0, o_data = 0, o_mode = 0, o_busy = 0.
- Priority each clock edge: clr > en > hold.
- clr = 1: all data and vld go to 0; mode unchanged.
- en = 1: stage 0 <= i_data[k] / i_valid[k]; stage s <= stage s-1.
- en = 0: all stages hold; i_valid and i_data are ignored (not captured).
- Output taps are combinational from registers:
  - Uniform mode: lane k taps stage DEPTH-1; latency DEPTH enabled cycles.
  - Skew mode: lane k taps stage k; latency k+1 enabled cycles.
- o_busy = OR of all vld bits across all lanes and stages.
- Mode register update:
  - mode <= skew_req only on an edge where o_busy = 0 and (en = 0 or i_valid = 0).
  - Otherwise mode holds; the request stays pending until the pipe drains.
  - clr drains the pipe, so the mode may update on the edge after clr.
- Boundary cases:
  - Stages beyond the skew tap keep shifting but are not observed.
  - Those unobserved stages still count toward o_busy.
- Data is passed bit-exact; there is no arithmetic and no width change.
- Reset mid-stream: all in-flight data is discarded immediately (async), and o_valid drops the same instant.

Optional Feature:
- Macro: IREG_SKEW_PIPE_ZERO_GATE_EN.
- Defined: stage 0 loads data = 0 whenever i_valid[k] = 0, so invalid slots carry zero padding into the PEs and downstream data toggling is reduced.
- Undefined: stage 0 loads i_data[k] regardless of valid; downstream must qualify data with o_valid.

Decomposition:
- Package ireg_pkg:
  - typedef lane_data_t (logic signed [WIDTH-1:0]), parameterised via a localparam default of 8.
  - typedef enum ireg_mode_e { IREG_UNIFORM = 0, IREG_SKEW = 1 }.
- Sub-module ireg_lane, one per lane (generate loop):
  - Parameters: WIDTH, DEPTH.
  - Contents: DEPTH-stage data+valid chain with en/clr, exposing all stage outputs.
- The top module owns the mode register, the tap muxes and o_busy.

Test Plan:
- Reset: hold rst_n = 0 with en = 1 and i_valid = 4'hF → o_valid = 0, o_data = 0, o_busy = 0; release rst_n → o_mode = 0.
- Uniform latency: mode 0, en = 1, inject lane data {8'sd4, 8'sd3, 8'sd2, -8'sd1} with i_valid = 4'hF for 1 cycle → all lanes emit those values with o_valid = 4'hF exactly 4 cycles later, for 1 cycle.
- Skew: set skew_req = 1 while idle → o_mode = 1 after 1 edge. Inject 8'sd7 on all lanes → lane k valid exactly at cycle k+1, for k = 0..3.
- Stall/clear: inject 1 valid word, drop en for 3 cycles → output delayed by exactly 3 cycles. Assert clr together with en mid-flight → o_busy = 0 next cycle and no valid emerges afterwards.
- Deferred mode: skew_req = 1 while o_busy = 1 → o_mode stays 0 until the cycle after the last vld clears, then becomes 1.
- Zero gate (macro defined): i_data = 8'sh5A with i_valid = 0 → stage data, and hence o_data, is 0. Macro undefined → 8'sh5A appears at the tap with o_valid = 0.
